// File: rtl/fb_rxreturn.sv
// FreeDM master return-frame checker: arms on a launch state, validates the returning frame and strobes *FrameReturned.
// Optional error counters (CrcErrCnt/TypeErrCnt/StrayCnt) are enabled by defining FB_RX_ERRCNT_EN.
module fb_rxreturn #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int MIN_LEN     = 4,
  parameter int CNT_W       = 20
) (
  input  logic             clk_top,
  input  logic             rst,
  input  logic             StateIdle,
  input  logic             StateNumb,
  input  logic             StateDist,
  input  logic             StateDelay,
  input  logic             StateDelayDist,
  input  logic             StateData,
  input  logic             RxValid,
  input  logic [7:0]       RxData,
  input  logic             RxSof,
  input  logic             RxEof,
  input  logic             RxCrcErr,
  output logic             NumbFrameReturned,
  output logic             DistFrameReturned,
  output logic             DelayFrameReturned,
  output logic             DelayDistFrameReturned,
  output logic             DataFrameReturned,
  output logic             ReturnTimeout,
  output logic [7:0]       NodeCount,
  output logic [CNT_W-1:0] RoundTripCnt
`ifdef FB_RX_ERRCNT_EN
  ,
  output logic [15:0]      CrcErrCnt,
  output logic [15:0]      TypeErrCnt,
  output logic [15:0]      StrayCnt
`endif
);

  localparam logic [7:0]       MIN_LEN_B = 8'(MIN_LEN);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {RX_IDLE, RX_BODY} rxState_t;

  rxState_t         r_state;
  logic             r_armed;
  logic [7:0]       r_expType;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_type;
  logic [7:0]       r_len;
  logic [7:0]       r_nodeTmp;
  logic [4:0]       r_strobe;
  logic             r_timeout;
  logic [7:0]       r_nodeCount;
  logic [CNT_W-1:0] r_rtt;

  logic             w_launch;
  logic [7:0]       w_launchType;
  logic             w_armedEff;
  logic [7:0]       w_expEff;
  logic [CNT_W-1:0] w_cntEff;
  logic             w_inBody;
  logic [7:0]       w_lenInc;
  logic             w_eof;
  logic [7:0]       w_evType;
  logic [7:0]       w_evLen;
  logic [7:0]       w_evNode;
  logic             w_accept;
  logic             w_timeout;
  logic             w_cntMax;
  logic [4:0]       w_strobeNext;

  assign w_launch = StateNumb | StateDist | StateDelay | StateDelayDist | StateData;

  always_comb begin
    w_launchType = 8'h00;
    if (StateNumb)           w_launchType = 8'h01;
    else if (StateDist)      w_launchType = 8'h02;
    else if (StateDelay)     w_launchType = 8'h03;
    else if (StateDelayDist) w_launchType = 8'h04;
    else if (StateData)      w_launchType = 8'h05;
  end

  // A launch in the same cycle as an EOF judges that frame against the new type.
  assign w_armedEff = r_armed | w_launch;
  assign w_expEff   = w_launch ? w_launchType : r_expType;
  assign w_cntEff   = w_launch ? '0 : r_cnt;

  assign w_inBody  = (r_state == RX_BODY);
  assign w_lenInc  = (r_len == 8'hFF) ? 8'hFF : r_len + 8'd1;
  assign w_eof     = RxValid & RxEof & (RxSof | w_inBody) & ~StateIdle;
  assign w_evType  = RxSof ? RxData : r_type;
  assign w_evLen   = RxSof ? 8'd1 : w_lenInc;
  assign w_evNode  = (r_len == 8'd1) ? RxData : r_nodeTmp;
  assign w_accept  = w_eof & w_armedEff & (w_evType == w_expEff) & ~RxCrcErr
                   & (w_evLen >= MIN_LEN_B);
  assign w_timeout = r_armed & (r_cnt == TO_LAST);
  assign w_cntMax  = &r_cnt;

  always_comb begin
    w_strobeNext = '0;
    case (w_expEff)
      8'h01:   w_strobeNext[0] = 1'b1;
      8'h02:   w_strobeNext[1] = 1'b1;
      8'h03:   w_strobeNext[2] = 1'b1;
      8'h04:   w_strobeNext[3] = 1'b1;
      8'h05:   w_strobeNext[4] = 1'b1;
      default: w_strobeNext = '0;
    endcase
  end

  // Priority: Idle disarm, then accept (beats a same-cycle timeout), then launch, then timeout.
  always_ff @(posedge clk_top) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_expType   <= 8'h00;
      r_cnt       <= '0;
      r_strobe    <= '0;
      r_timeout   <= 1'b0;
      r_nodeCount <= 8'h00;
      r_rtt       <= '0;
    end else begin
      r_strobe  <= '0;
      r_timeout <= 1'b0;
      if (StateIdle) begin
        r_armed <= 1'b0;
      end else if (w_accept) begin
        r_armed     <= 1'b0;
        r_strobe    <= w_strobeNext;
        r_nodeCount <= w_evNode;
        r_rtt       <= w_cntEff;
      end else if (w_launch) begin
        r_armed   <= 1'b1;
        r_expType <= w_launchType;
        r_cnt     <= '0;
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
        r_armed   <= 1'b0;
      end else if (r_armed && !w_cntMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Frame parser; the type byte is handled in the SOF cycle itself, so only IDLE/BODY remain.
  always_ff @(posedge clk_top) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_type    <= 8'h00;
      r_len     <= 8'h00;
      r_nodeTmp <= 8'h00;
    end else if (StateIdle) begin
      r_state <= RX_IDLE;
    end else if (RxValid) begin
      if (RxSof) begin
        r_type  <= RxData;
        r_len   <= 8'd1;
        r_state <= RxEof ? RX_IDLE : RX_BODY;
      end else if (w_inBody) begin
        r_len <= w_lenInc;
        if (r_len == 8'd1) r_nodeTmp <= RxData;
        if (RxEof) r_state <= RX_IDLE;
      end
    end
  end

`ifdef FB_RX_ERRCNT_EN
  always_ff @(posedge clk_top) begin
    if (rst) begin
      CrcErrCnt  <= 16'h0000;
      TypeErrCnt <= 16'h0000;
      StrayCnt   <= 16'h0000;
    end else if (w_eof) begin
      if (RxCrcErr && CrcErrCnt != 16'hFFFF)
        CrcErrCnt <= CrcErrCnt + 16'd1;
      if (w_armedEff && (w_evType != w_expEff) && TypeErrCnt != 16'hFFFF)
        TypeErrCnt <= TypeErrCnt + 16'd1;
      if (!w_armedEff && StrayCnt != 16'hFFFF)
        StrayCnt <= StrayCnt + 16'd1;
    end
  end
`endif

  assign NumbFrameReturned      = r_strobe[0];
  assign DistFrameReturned      = r_strobe[1];
  assign DelayFrameReturned     = r_strobe[2];
  assign DelayDistFrameReturned = r_strobe[3];
  assign DataFrameReturned      = r_strobe[4];
  assign ReturnTimeout          = r_timeout;
  assign NodeCount              = r_nodeCount;
  assign RoundTripCnt           = r_rtt;

endmodule
